// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the writeback-bus arbiter.
//   WB_DATA_W / WB_TAG_W / WB_NREQ : result width, tag width, producer count
//   SRC_*                          : producer index of each execution unit
//   onehot4()                      : 2-bit index to 4-bit one-hot grant vector
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_TAG_W  = 5;
    localparam int WB_NREQ   = 4;

    localparam logic [1:0] SRC_ALU0 = 2'd0;
    localparam logic [1:0] SRC_ALU1 = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;
    localparam logic [1:0] SRC_MULT = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way round-robin pick.
//   req [3:0] : request vector
//   ptr [1:0] : index holding highest priority this cycle
//   any       : at least one request is set
//   g   [1:0] : winning index (first set bit at or after ptr, modulo 4)
// The request vector is rotated so that ptr lands on bit 0, a fixed
// priority encoder picks the lowest set bit, and the result is rotated back
// by adding ptr (2-bit wrap does the modulo).
module rr_pick4
    import wb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] g
);

    logic [3:0] rot;
    logic [1:0] idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = req[ptr + 2'(gi)];
        end
    endgenerate

    always_comb begin
        idx = 2'd0;
        if (rot[0])      idx = 2'd0;
        else if (rot[1]) idx = 2'd1;
        else if (rot[2]) idx = 2'd2;
        else if (rot[3]) idx = 2'd3;
    end

    assign any = |req;
    assign g   = idx + ptr;

endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin arbiter plus single-entry output register that
// shares one writeback bus among four producers (ALU0, ALU1, MEM, MULT).
//   clk, rst_n         : core clock, asynchronous active-low reset
//   req_valid/ready    : per-producer handshake, ready is a one-hot grant
//   req_data/req_tag   : packed producer results and destination tags
//   flush              : squash the output register, no grant that cycle
//   out_valid/ready    : handshake toward the register-file write port
//   out_data/tag/src   : registered winning result, tag and producer index
//   rr_ptr             : current highest-priority producer index
module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int TAG_W  = WB_TAG_W,
    parameter int NREQ   = WB_NREQ
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*TAG_W-1:0]  req_tag,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [1:0]             out_src,
    output logic [1:0]             rr_ptr
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
    logic [1:0]        out_src_q,   out_src_d;
    logic [1:0]        rr_ptr_q,    rr_ptr_d;

    logic              load_en;
    logic              grant_fire;
    logic              pick_any;
    logic [1:0]        pick_g;

    logic [DATA_W-1:0] data_arr [NREQ];
    logic [TAG_W-1:0]  tag_arr  [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
            assign tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
        end
    endgenerate

    rr_pick4 u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .g   (pick_g)
    );

    // The register can take a new entry when empty or draining this cycle;
    // flush blocks loading so nothing is consumed from a producer.
    assign load_en = (!out_valid_q || out_ready) && !flush;

    // rst_n gates the grant so no producer believes it was consumed while
    // the arbiter is held in reset.
    assign grant_fire = load_en && pick_any && rst_n;
    assign req_ready  = grant_fire ? onehot4(pick_g) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (grant_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = data_arr[pick_g];
            out_tag_d   = tag_arr[pick_g];
            out_src_d   = pick_g;
            rr_ptr_d    = pick_g + 2'd1;
        end else if (load_en) begin
            // Drained with nothing to replace it; payload fields keep
            // their last values to avoid needless toggling.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_src_q   <= SRC_ALU0;
            rr_ptr_q    <= SRC_ALU0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_src   = out_src_q;
    assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: table-driven vectors, hand-written multi-cycle corner
// sequences, and a randomized run checked against a behavioural model.
module tb_wb_bus_arbiter;
    import wb_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [19:0]  req_tag;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [4:0]   out_tag;
    logic [1:0]   out_src;
    logic [1:0]   rr_ptr;

    logic [31:0]  d [4];
    logic [4:0]   t [4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        req_tag  = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[32*i +: 32] = d[i];
            req_tag[5*i +: 5]    = t[i];
        end
    end

    wb_bus_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_src   (out_src),
        .rr_ptr    (rr_ptr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] base_data(input int i);
        return 32'h1000_0000 * (i + 1) + 32'h55;
    endfunction

    task automatic load_base();
        for (int i = 0; i < 4; i++) begin
            d[i] = base_data(i);
            t[i] = 5'(10 + i);
        end
    endtask

    // Inputs change just after a rising edge; everything is sampled on the
    // falling edge that follows.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       oready;
        logic       flsh;
        logic [3:0] exp_ready;
        logic       exp_ov;
        logic [1:0] exp_src;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t vecs [15];

    // Behavioural reference model for the random run.
    logic        m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_tag;
    int          m_src;
    int          m_ptr;

    initial begin
        logic [3:0] exp_rdy;
        int         g;
        bit         gfound;
        bit         load;

        rst_n     = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        flush     = 1'b0;
        load_base();

        // Register contents after each row's edge are the next row's
        // expectations: {valid, oready, flush, ready, out_valid, src, ptr}.
        vecs[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 2'd0};
        vecs[5]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 2'd1};
        vecs[6]  = '{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd1, 2'd2};
        vecs[7]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 2'd1};
        vecs[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd2};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 2'd2};
        vecs[10] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd1, 2'd2};
        vecs[11] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 2'd0};
        vecs[12] = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd3, 2'd0};
        vecs[13] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd3, 2'd0};
        vecs[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd1};

        // ---- 1. reset then idle ----
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_rr_ptr",    64'(rr_ptr),    64'd0);
            next_cycle();
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_grant", 64'(req_ready), 64'b0001);
        next_cycle();
        @(negedge clk);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_data",  64'(out_data),  64'(base_data(0)));
        chk("t1_out_src",   64'(out_src),   64'(SRC_ALU0));

        // ---- 2/3. table-driven rotation, sparse wrap, idle, stall, flush ----
        do_reset();
        for (int v = 0; v < 15; v++) begin
            req_valid = vecs[v].valid;
            out_ready = vecs[v].oready;
            flush     = vecs[v].flsh;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
            chk($sformatf("vec%0d_ov", v),    64'(out_valid), 64'(vecs[v].exp_ov));
            chk($sformatf("vec%0d_src", v),   64'(out_src),   64'(vecs[v].exp_src));
            chk($sformatf("vec%0d_ptr", v),   64'(rr_ptr),    64'(vecs[v].exp_ptr));
            if (vecs[v].exp_ov) begin
                chk($sformatf("vec%0d_data", v), 64'(out_data), 64'(base_data(int'(vecs[v].exp_src))));
                chk($sformatf("vec%0d_tag", v),  64'(out_tag),  64'(10 + int'(vecs[v].exp_src)));
            end
            next_cycle();
        end
        flush = 1'b0;

        // ---- 4. backpressure ----
        req_valid = 4'b0000;
        out_ready = 1'b1;
        do_reset();
        d[0] = 32'hDEADBEEF;
        t[0] = 5'd7;
        req_valid = 4'b0001;
        next_cycle();
        load_base();
        req_valid = 4'b0100;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_ov",    64'(out_valid), 64'd1);
            chk("bp_data",  64'(out_data),  64'h0000_0000_DEAD_BEEF);
            chk("bp_tag",   64'(out_tag),   64'd7);
            chk("bp_src",   64'(out_src),   64'd0);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(req_ready), 64'b0100);
        chk("bp_release_data",  64'(out_data),  64'h0000_0000_DEAD_BEEF);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("bp_after_data", 64'(out_data), 64'(base_data(2)));
        chk("bp_after_src",  64'(out_src),  64'(SRC_MEM));
        chk("bp_after_ptr",  64'(rr_ptr),   64'd3);

        // ---- 5. flush ----
        do_reset();
        req_valid = 4'b0001;
        next_cycle();
        req_valid = 4'b1000;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_ready", 64'(req_ready), 64'd0);
        chk("fl_ov_before", 64'(out_valid), 64'd1);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_ov_after", 64'(out_valid), 64'd0);
        chk("fl_ptr",      64'(rr_ptr),    64'd1);
        chk("fl_regrant",  64'(req_ready), 64'b1000);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("fl_src", 64'(out_src), 64'(SRC_MULT));

        // ---- 6. asynchronous reset mid-stream ----
        do_reset();
        req_valid = 4'b0100;
        next_cycle();
        req_valid = 4'b1111;
        out_ready = 1'b0;
        @(negedge clk);
        chk("ar_pre_ptr", 64'(rr_ptr),    64'd3);
        chk("ar_pre_ov",  64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ov",    64'(out_valid), 64'd0);
        chk("ar_ptr",   64'(rr_ptr),    64'd0);
        chk("ar_data",  64'(out_data),  64'd0);
        chk("ar_src",   64'(out_src),   64'd0);
        chk("ar_ready", 64'(req_ready), 64'd0);
        next_cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ar_first_grant", 64'(req_ready), 64'b0001);

        // ---- randomized run against the behavioural model ----
        req_valid = 4'b0000;
        do_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_tag   = '0;
        m_src   = 0;
        m_ptr   = 0;
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            load    = (!m_valid || out_ready) && !flush;
            gfound  = 1'b0;
            g       = 0;
            for (int k = 0; k < 4; k++) begin
                if (!gfound && req_valid[(m_ptr + k) % 4]) begin
                    gfound = 1'b1;
                    g      = (m_ptr + k) % 4;
                end
            end
            exp_rdy = (load && gfound) ? 4'(1 << g) : 4'b0000;
            chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rnd_ov",    64'(out_valid), 64'(m_valid));
            chk("rnd_data",  64'(out_data),  64'(m_data));
            chk("rnd_tag",   64'(out_tag),   64'(m_tag));
            chk("rnd_src",   64'(out_src),   64'(m_src));
            chk("rnd_ptr",   64'(rr_ptr),    64'(m_ptr));
            if (flush) begin
                m_valid = 1'b0;
            end else if (load && gfound) begin
                m_valid = 1'b1;
                m_data  = d[g];
                m_tag   = t[g];
                m_src   = g;
                m_ptr   = (g + 1) % 4;
            end else if (load) begin
                m_valid = 1'b0;
            end
            next_cycle();
            // Producers hold their offer until granted, then may re-offer.
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || exp_rdy[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    d[i]         = $urandom;
                    t[i]         = 5'($urandom_range(0, 31));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
